cam_frame_writer: RTL
=====================

Name: cam_frame_writer

Overview:
- Captures an RGB565 byte stream from an OV7670-style camera and writes 3-bit RGB111 pixels into the frame buffer's write port (addr_in / data_in / regwrite).
- Sits between the camera pins and the dual-port buffer RAM; the VGA side reads the same buffer.
- All camera inputs are oversampled in the single system clock domain; there is no second clock.

Parameters:
- AW, 15, frame buffer address width; must satisfy 2**AW >= IMG_W*IMG_H.
- DW, 3, pixel width written to the buffer; fixed at 3 (R,G,B one bit each).
- IMG_W, 160, pixels per line.
- IMG_H, 120, lines per frame.

Ports:
- clk  in  1  system clock; must be >= 4x the cam_pclk frequency.
- reset  in  1  synchronous, active-low reset.
- cam_pclk  in  1  camera pixel clock, treated as data.
- cam_href  in  1  camera line-valid.
- cam_vsync  in  1  camera frame sync; high = vertical blanking.
- cam_data  in  8  camera byte bus.
- addr_in  out  AW  buffer write address.
- data_in  out  DW  buffer write data, RGB111.
- regwrite  out  1  buffer write strobe, one-cycle pulse per pixel.
- frame_done  out  1  one-cycle pulse at end of each captured frame.
- overflow  out  1  sticky; the frame carried more than IMG_W*IMG_H pixels.
- busy  out  1  high while in CAPTURE.

Behaviour:
- Input sync: cam_pclk, cam_href, cam_vsync and cam_data each pass through a 2-flop synchronizer. pclk_rise = sync_pclk & ~prev_pclk. vsync_rise and vsync_fall are detected the same way.
- Reset (reset==0 at a clk edge):
  - state=IDLE; addr_in=0, data_in=0, regwrite=0, frame_done=0, overflow=0, busy=0.
  - byte phase=0; synchronizer flops cleared.
  - Reset mid-frame abandons the frame: no frame_done is produced, and already-written pixels are left in the RAM.
- FSM states and transitions:
  - IDLE: wait for sync_vsync==1, then go to WAIT_FRAME. This ensures capture never starts mid-frame after reset.
  - WAIT_FRAME: on vsync_fall, go to CAPTURE. Entering CAPTURE clears the pixel counter to 0, clears overflow and clears byte phase.
  - CAPTURE: busy=1.
    - On pclk_rise with sync_href=1, phase 0: latch byte as hi_byte; set phase=1.
    - On pclk_rise with sync_href=1, phase 1: form the pixel {hi_byte[7], hi_byte[2], sync_data[4]} (R msb, G msb, B msb); set phase=0.
    - sync_href==0 forces phase=0 on every cycle, so a dangling first byte is discarded.
    - On vsync_rise, pulse frame_done for one cycle and go to WAIT_FRAME.
- Write timing:
  - The cycle after the phase-1 pclk_rise: regwrite=1, addr_in=pixel counter, data_in=pixel.
  - The pixel counter increments on that same cycle. Write latency from the phase-1 sync'd edge is 1 clk.
  - regwrite is 0 in every other cycle.
  - addr_in and data_in hold their last values between writes.
- Bounds:
  - Counter range is 0..IMG_W*IMG_H-1.
  - When the counter equals IMG_W*IMG_H and another pixel completes: no write, overflow=1, counter holds. There is no wrap.
  - overflow stays 1 until the next CAPTURE entry or reset.
  - A short frame (vsync_rise before IMG_W*IMG_H pixels) still pulses frame_done; the unwritten RAM locations keep their old contents.
- Simultaneous events: if vsync_rise and a phase-1 pclk_rise occur in the same cycle, the pixel write still happens, then frame_done pulses and the FSM goes to WAIT_FRAME.
- frame_done and regwrite may be high in the same cycle.
- All outputs are registered.

Test Plan:
- Reset, then hold vsync low with pclk toggling -> FSM stays IDLE, regwrite never asserts, busy=0.
- IMG_W=4, IMG_H=2; vsync high then low; 8 byte pairs (0xF8,0x1F) with href=1; then vsync high:
  - expect 8 regwrite pulses at addr 0..7, each with data_in=3'b101;
  - expect one frame_done pulse and overflow=0.
- Byte pair (0x07,0xE0) -> data_in=3'b010; pair (0x00,0x00) -> 3'b000; pair (0xFF,0xFF) -> 3'b111.
- href drops after a single byte, then 2 full pairs follow -> only 2 writes, at addr n and n+1. The orphan byte is never paired.
- IMG_W=4, IMG_H=2 with 10 pixels sent:
  - expect writes at addr 0..7 only, then overflow=1;
  - the next frame start clears overflow and restarts at addr 0.
- reset low for 1 clk after 3 pixels of a frame -> all outputs return to reset values and the FSM is in IDLE. The remainder of that frame produces no writes; the following full frame captures from addr 0.

Source files
------------

// File: rtl/cam_frame_writer.sv
// cam_frame_writer: oversamples an OV7670 RGB565 byte stream and writes RGB111 pixels
// into the frame buffer write port, one address per pixel, never past the frame end.
`timescale 1ns/1ps
module cam_frame_writer #(
    parameter int AW    = 15,
    parameter int DW    = 3,
    parameter int IMG_W = 160,
    parameter int IMG_H = 120
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cam_pclk,
    input  logic          cam_href,
    input  logic          cam_vsync,
    input  logic [7:0]    cam_data,
    output logic [AW-1:0] addr_in,
    output logic [DW-1:0] data_in,
    output logic          regwrite,
    output logic          frame_done,
    output logic          overflow,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, WAIT_FRAME, CAPTURE} state_t;

    // One extra counter bit so the full-frame value is representable even when 2**AW is exact.
    localparam logic [AW:0] NPIX = (AW+1)'(IMG_W * IMG_H);

    state_t        state_q, state_d;
    logic [1:0]    pclk_s_q, href_s_q, vsync_s_q;
    logic [7:0]    data_s1_q, data_s_q;
    logic          pclk_prev_q, vsync_prev_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic [1:0]    hi_q, hi_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          regwrite_q, regwrite_d;
    logic          frame_done_q, frame_done_d;
    logic          overflow_q, overflow_d;
    logic          busy_q, busy_d;
    logic          pclk_rise, vsync_rise, vsync_fall, href_s, vsync_s;
    logic          unused_bits;

    assign href_s      = href_s_q[1];
    assign vsync_s     = vsync_s_q[1];
    assign pclk_rise   = pclk_s_q[1] & ~pclk_prev_q;
    assign vsync_rise  = vsync_s & ~vsync_prev_q;
    assign vsync_fall  = ~vsync_s & vsync_prev_q;
    assign unused_bits = ^{data_s_q[6:5], data_s_q[3], data_s_q[1:0]};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        phase_d      = phase_q;
        hi_d         = hi_q;
        addr_d       = addr_q;
        data_d       = data_q;
        regwrite_d   = 1'b0;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;
        case (state_q)
            IDLE:       if (vsync_s) state_d = WAIT_FRAME;
            WAIT_FRAME: if (vsync_fall) begin
                state_d    = CAPTURE;
                cnt_d      = '0;
                overflow_d = 1'b0;
                phase_d    = 1'b0;
            end
            CAPTURE: begin
                if (!href_s) phase_d = 1'b0;
                else if (pclk_rise && !phase_q) begin
                    hi_d    = {data_s_q[7], data_s_q[2]};
                    phase_d = 1'b1;
                end else if (pclk_rise) begin
                    phase_d = 1'b0;
                    if (cnt_q == NPIX) overflow_d = 1'b1;
                    else begin
                        regwrite_d = 1'b1;
                        addr_d     = cnt_q[AW-1:0];
                        data_d     = {hi_q, data_s_q[4]};
                        cnt_d      = cnt_q + (AW+1)'(1);
                    end
                end
                if (vsync_rise) begin
                    frame_done_d = 1'b1;
                    state_d      = WAIT_FRAME;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == CAPTURE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            pclk_s_q     <= '0;
            href_s_q     <= '0;
            vsync_s_q    <= '0;
            data_s1_q    <= '0;
            data_s_q     <= '0;
            pclk_prev_q  <= 1'b0;
            vsync_prev_q <= 1'b0;
            cnt_q        <= '0;
            phase_q      <= 1'b0;
            hi_q         <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            regwrite_q   <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pclk_s_q     <= {pclk_s_q[0], cam_pclk};
            href_s_q     <= {href_s_q[0], cam_href};
            vsync_s_q    <= {vsync_s_q[0], cam_vsync};
            data_s1_q    <= cam_data;
            data_s_q     <= data_s1_q;
            pclk_prev_q  <= pclk_s_q[1];
            vsync_prev_q <= vsync_s;
            cnt_q        <= cnt_d;
            phase_q      <= phase_d;
            hi_q         <= hi_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            regwrite_q   <= regwrite_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            busy_q       <= busy_d;
        end
    end

    assign addr_in    = addr_q;
    assign data_in    = data_q;
    assign regwrite   = regwrite_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
    assign busy       = busy_q;
endmodule
